tft_timing_gen: RTL and testbench
=================================

Name: tft_timing_gen

Overview:
Generates the TFT-LCD raster timing that drives the LCD controller stage and its BRAM controller: the pixel clock enable, Hsync, Vsync, data-enable, and the active-area pixel coordinates. The block runs from the system clock CLK. A programmable divider produces the pixel rate. A run/stop FSM starts and stops output only on frame boundaries, so the downstream BRAM line and frame counters never see a partial frame.

Parameters:
- CLK_DIV, 4: CLK cycles per pixel; must be ≥ 2.
- H_SYNC, 41: Hsync width in pixels.
- H_BP, 2: horizontal back porch, in pixels.
- H_ACTIVE, 480: visible pixels per line.
- H_FP, 2: horizontal front porch, in pixels.
- V_SYNC, 10: Vsync width in lines.
- V_BP, 2: vertical back porch, in lines.
- V_ACTIVE, 272: visible lines per frame.
- V_FP, 2: vertical front porch, in lines.
- SYNC_ACT, 0: asserted level of Hsync and Vsync.

Ports:
- CLK, in, 1: system clock.
- nRESET, in, 1: synchronous, active-low reset.
- enable, in, 1: run request; sampled every CLK.
- pix_ce, out, 1: one-CLK pulse per pixel; feeds TCLK generation.
- Hsync, out, 1: horizontal sync, at polarity SYNC_ACT.
- Vsync, out, 1: vertical sync, at polarity SYNC_ACT.
- DE, out, 1: high inside the active area.
- pix_x, out, 10: active column, 0..H_ACTIVE-1; 0 outside the active area.
- pix_y, out, 10: active row, 0..V_ACTIVE-1; 0 outside the active area.
- line_start, out, 1: pulse at h_cnt=0 of every line while running.
- frame_start, out, 1: pulse at h_cnt=0, v_cnt=0.
- busy, out, 1: high in RUN and DRAIN.

Behaviour:
- Reset is synchronous: nRESET sampled low at a CLK edge takes effect at that edge. It applies at any time, including mid-frame.
- Reset values:
  - div_cnt=0, pix_ce=0.
  - h_cnt=0, v_cnt=0.
  - Hsync=Vsync=~SYNC_ACT.
  - DE=0, pix_x=0, pix_y=0.
  - line_start=0, frame_start=0, busy=0.
  - FSM=IDLE.
- Totals: H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP (525 default); V_TOTAL likewise (286 default). Elaboration fails if either total exceeds 1023.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - pix_ce=1 on the CLK cycle where div_cnt==CLK_DIV-1.
  - The divider free-runs in every FSM state except reset, so TCLK stays alive while idle.
- Counters advance only on pix_ce in RUN or DRAIN.
  - h_cnt wraps H_TOTAL-1 → 0, incrementing v_cnt.
  - v_cnt wraps V_TOTAL-1 → 0.
- Line layout by h_cnt:
  - [0, H_SYNC): sync.
  - [H_SYNC, H_SYNC+H_BP): back porch.
  - next H_ACTIVE counts: active.
  - remainder: front porch.
  - The vertical layout is the same, counted in lines.
- Output decode:
  - All outputs are registered and decoded from the counter state. They update on the CLK edge on which the counters update, i.e. zero pixel latency relative to the counters.
  - DE = h_active & v_active.
  - pix_x = h_cnt-(H_SYNC+H_BP) when DE, else 0. pix_y is the same rule in the vertical direction.
  - Vsync changes only at h_cnt=0 boundaries.
  - line_start and frame_start are one pix_ce period wide, i.e. held for CLK_DIV CLK cycles.
- FSM:
  - IDLE: counters held at 0; syncs inactive; DE=0; no pulses.
  - IDLE → RUN on the first pix_ce with enable=1. That edge emits h_cnt=0, v_cnt=0, frame_start=1, line_start=1.
  - RUN → DRAIN when enable=0 is sampled at any time.
  - DRAIN → RUN if enable returns to 1 before the frame ends; no glitch and no restart.
  - DRAIN → IDLE on the pix_ce that would wrap h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 to 0. That edge clears all outputs and emits no frame_start.
  - From RUN, that same wrap continues into a new frame with frame_start=1.
- Simultaneous events:
  - Reset dominates everything.
  - enable toggles between pix_ce pulses: only the last value sampled before the frame wrap decides.

Decomposition:
- Package tft_timing_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN);
  - the default 480x272 timing constants;
  - the H_TOTAL/V_TOTAL derivation function.
- One sub-module, tft_axis_counter, is instantiated twice (horizontal, vertical). It is parameterised by sync, back-porch, active and front-porch lengths. Ports: advance, clear; outputs: count, wrap, sync, active.

Test Plan:
1. Reset with enable=1 held, then release: first pix_ce on the 4th CLK after release → frame_start=1, Hsync=Vsync=0. Hsync rises at h_cnt=41 (164 CLK later).
2. Full frame, defaults: DE high for exactly 480×272=130560 pixels. The first DE is at h_cnt=43, v_cnt=12 with pix_x=0, pix_y=0. The last DE has pix_x=479, pix_y=271. frame_start period = 525×286×4 = 600600 CLK.
3. Drop enable mid-frame (v_cnt=100): busy stays 1. Outputs continue unchanged until the h=524, v=285 wrap, then go to IDLE with Hsync=Vsync=1, DE=0, no frame_start.
4. Drop enable at v_cnt=100, re-raise at v_cnt=200: no interruption; next frame_start exactly 600600 CLK after the previous one.
5. nRESET low for one CLK at h_cnt=300 in an active line → the next edge shows all outputs at reset values and FSM=IDLE.
6. CLK_DIV=2, H_ACTIVE=8, all porches/syncs=1, V_ACTIVE=4: verify the exact Hsync/DE waveform per line (11-pixel line = 22 CLK) and pix_x sequence 0..7.

Source files
------------

// File: rtl/tft_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_timing_pkg
// Brief    : Shared types, default 480x272 panel timing, axis-total helper.
// Revision : 1.0
// ============================================================================
package tft_timing_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tft_state_e;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_SYNC_ACT = 0;

  function automatic int axis_total(input int sync, input int bp,
                                    input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tft_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : tft_axis_counter
// Brief    : One raster axis counter; outputs describe the value loaded this edge.
// Revision : 1.0
// ============================================================================
module tft_axis_counter
  import tft_timing_pkg::*;
#(
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             advance,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);

  if (TOTAL > 1023) begin : g_total_check
    $error("tft_axis_counter: axis total exceeds 1023");
  end

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_LO  = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] ACT_HI  = CNT_W'(SYNC + BP + ACTIVE);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    wrap    = advance && (count_q == LAST);
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Decode the incoming value so the parent registers timing with no lag.
  assign count  = count_d;
  assign sync   = (count_d < SYNC_HI);
  assign active = (count_d >= ACT_LO) && (count_d < ACT_HI);

endmodule
`default_nettype wire

// File: rtl/tft_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tft_timing_gen
// Brief    : TFT raster timing with pixel divider and frame-aligned run/stop.
// Revision : 1.0
// ============================================================================
module tft_timing_gen
  import tft_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int SYNC_ACT = DEF_SYNC_ACT
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       enable,
  output logic       pix_ce,
  output logic       Hsync,
  output logic       Vsync,
  output logic       DE,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       busy
);

  if (CLK_DIV < 2) begin : g_div_check
    $error("tft_timing_gen: CLK_DIV must be at least 2");
  end

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_OFS    = 10'(H_SYNC + H_BP);
  localparam logic [9:0]       V_OFS    = 10'(V_SYNC + V_BP);
  localparam logic             SYNC_ON  = (SYNC_ACT != 0);
  localparam logic             SYNC_OFF = !SYNC_ON;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_ce_q, pix_ce_d;
  tft_state_e       state_q, state_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [9:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic             busy_q, busy_d;

  logic             tick, h_adv, cnt_clear, de_w;
  logic [9:0]       h_count, v_count;
  logic             h_wrap, v_wrap, h_sync, v_sync, h_active, v_active;

  assign tick      = pix_ce_q;
  assign h_adv     = tick && (state_q != ST_IDLE);
  assign cnt_clear = (state_q == ST_IDLE);

  tft_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)
  ) u_h_cnt (
    .CLK(CLK), .nRESET(nRESET), .advance(h_adv), .clear(cnt_clear),
    .count(h_count), .wrap(h_wrap), .sync(h_sync), .active(h_active)
  );

  tft_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)
  ) u_v_cnt (
    .CLK(CLK), .nRESET(nRESET), .advance(h_wrap), .clear(cnt_clear),
    .count(v_count), .wrap(v_wrap), .sync(v_sync), .active(v_active)
  );

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_ce_d  = (div_cnt_d == DIV_LAST);
  end

  // enable is resampled every CLK, so only its value at the frame wrap matters.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick && enable) state_d = ST_RUN;
      ST_RUN,
      ST_DRAIN: begin
        if (v_wrap) state_d = enable ? ST_RUN : ST_IDLE;
        else        state_d = enable ? ST_RUN : ST_DRAIN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign de_w = h_active && v_active;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    busy_d        = (state_d != ST_IDLE);
    if (tick) begin
      if (state_d == ST_IDLE) begin
        hsync_d       = SYNC_OFF;
        vsync_d       = SYNC_OFF;
        de_d          = 1'b0;
        pix_x_d       = '0;
        pix_y_d       = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
      end else begin
        hsync_d       = h_sync ? SYNC_ON : SYNC_OFF;
        vsync_d       = v_sync ? SYNC_ON : SYNC_OFF;
        de_d          = de_w;
        pix_x_d       = de_w ? h_count - H_OFS : '0;
        pix_y_d       = de_w ? v_count - V_OFS : '0;
        line_start_d  = (h_count == '0);
        frame_start_d = (h_count == '0) && (v_count == '0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      div_cnt_q     <= '0;
      pix_ce_q      <= 1'b0;
      state_q       <= ST_IDLE;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_ce_q      <= pix_ce_d;
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign DE          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tft_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_timing_gen
// Brief    : Scoreboard bench for tft_timing_gen on an 11x7 raster, CLK_DIV=2.
// Revision : 1.0
// ============================================================================
module tb_tft_timing_gen;

  localparam int CLK_DIV  = 2;
  localparam int H_SYNC   = 1;
  localparam int H_BP     = 1;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int H_TOTAL  = 11;
  localparam int V_TOTAL  = 7;
  localparam int FRAME_CLK = 154;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       enable = 1'b1;
  logic       pix_ce, Hsync, Vsync, DE, line_start, frame_start, busy;
  logic [9:0] pix_x, pix_y;

  tft_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .H_FP(H_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .V_FP(V_FP), .SYNC_ACT(0)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .enable(enable), .pix_ce(pix_ce),
    .Hsync(Hsync), .Vsync(Vsync), .DE(DE), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int sb_count = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] px;
    logic [9:0] py;
    logic       ls;
    logic       fs;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t pixel_obs(input int h, input int v);
    obs_t o;
    logic ha, va;
    ha     = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE);
    va     = (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
    o.hs   = (h < H_SYNC) ? 1'b0 : 1'b1;
    o.vs   = (v < V_SYNC) ? 1'b0 : 1'b1;
    o.de   = ha && va;
    o.px   = o.de ? 10'(h - (H_SYNC + H_BP)) : 10'd0;
    o.py   = o.de ? 10'(v - (V_SYNC + V_BP)) : 10'd0;
    o.ls   = (h == 0);
    o.fs   = (h == 0) && (v == 0);
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected-response producer: one entry per pixel tick.
  bit m_running = 1'b0;
  int m_h = 0;
  int m_v = 0;

  initial begin
    forever begin
      @(posedge CLK);
      if (nRESET !== 1'b1) begin
        m_running = 1'b0;
      end else if (pix_ce === 1'b1) begin
        if (!m_running) begin
          if (enable) begin
            m_running = 1'b1;
            m_h = 0;
            m_v = 0;
            exp_q.push_back(pixel_obs(0, 0));
          end else begin
            exp_q.push_back(idle_obs());
          end
        end else begin
          m_h++;
          if (m_h == H_TOTAL) begin
            m_h = 0;
            m_v++;
            if (m_v == V_TOTAL) m_v = 0;
          end
          if (m_h == 0 && m_v == 0 && !enable) begin
            m_running = 1'b0;
            exp_q.push_back(idle_obs());
          end else begin
            exp_q.push_back(pixel_obs(m_h, m_v));
          end
        end
      end
    end
  end

  // Monitor: compares the outputs presented after every pixel tick.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge CLK);
      if (nRESET === 1'b1 && pix_ce === 1'b1) begin
        #1;
        a = {Hsync, Vsync, DE, pix_x, pix_y, line_start, frame_start, busy};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: no expected entry for output 0x%0h", a);
        end else begin
          e = exp_q.pop_front();
          sb_count++;
          if (a !== e) begin
            fails++;
            $display("FAIL pixel_outputs: got 0x%0h, expected 0x%0h at cyc %0d", a, e, cyc);
          end
        end
      end
    end
  end

  task automatic wait_fs(output int t);
    logic prev;
    prev = frame_start;
    t = -1;
    for (int n = 0; n < 400; n++) begin
      @(posedge CLK);
      #1;
      if (frame_start && !prev) begin
        t = cyc;
        break;
      end
      prev = frame_start;
    end
    if (t < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_frame_start: got none, expected one within 400 CLK");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, tr;
    int de_cnt, fs_at, fs_hits, busy_low;
    logic prev_fs, first_seen;
    logic [9:0] fx, fy, lx, ly;

    // Reset with enable held, then release.
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs",
          {Hsync, Vsync, DE, pix_x, pix_y, line_start, frame_start, busy, pix_ce},
          {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 4'b0000});
    @(negedge CLK) nRESET = 1'b1;
    @(posedge CLK); #1;
    check("first_pix_ce", pix_ce, 1);
    check("no_fs_before_tick", frame_start, 0);
    @(posedge CLK); #1;
    t0 = cyc;
    check("first_frame_start", frame_start, 1);
    check("first_line_start", line_start, 1);
    check("first_syncs_low", {Hsync, Vsync}, 2'b00);
    check("busy_after_start", busy, 1);

    // One full frame sweep.
    de_cnt = 0; fs_at = 0; prev_fs = 1'b1; first_seen = 1'b0;
    fx = '0; fy = '0; lx = '0; ly = '0;
    for (int k = 1; k <= FRAME_CLK; k++) begin
      @(posedge CLK); #1;
      if (k == 1) check("hsync_held_in_sync", Hsync, 0);
      if (k == 2) check("hsync_rise_at_h1", Hsync, 1);
      if (DE) begin
        de_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          fx = pix_x;
          fy = pix_y;
        end
        lx = pix_x;
        ly = pix_y;
      end
      if (frame_start && !prev_fs && fs_at == 0) fs_at = k;
      prev_fs = frame_start;
    end
    check("de_clk_count", de_cnt, 64);
    check("first_de_xy", {fx, fy}, {10'd0, 10'd0});
    check("last_de_xy", {lx, ly}, {10'd7, 10'd3});
    check("frame_period", fs_at, FRAME_CLK);
    check("frame_period_cyc", cyc - t0, FRAME_CLK);

    // Drop enable at line 3; frame must finish then go idle.
    repeat (66) @(posedge CLK);
    @(negedge CLK) enable = 1'b0;
    repeat (87) @(posedge CLK);
    #1;
    check("busy_while_draining", busy, 1);
    @(posedge CLK); #1;
    check("idle_after_drain", {Hsync, Vsync, DE, busy, frame_start, line_start},
          6'b110000);
    fs_hits = 0;
    busy_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (frame_start) fs_hits++;
      if (busy) busy_low++;
    end
    check("no_fs_while_idle", fs_hits, 0);
    check("no_busy_while_idle", busy_low, 0);

    // Drop at line 2, re-raise at line 5: frame continues uninterrupted.
    @(negedge CLK) enable = 1'b1;
    wait_fs(t0);
    repeat (44) @(posedge CLK);
    @(negedge CLK) enable = 1'b0;
    busy_low = 0;
    for (int k = 0; k < 66; k++) begin
      @(posedge CLK); #1;
      if (!busy) busy_low++;
    end
    @(negedge CLK) enable = 1'b1;
    wait_fs(t1);
    check("reenable_frame_period", t1 - t0, FRAME_CLK);
    check("reenable_busy_held", busy_low, 0);

    // Reset pulse inside an active line.
    repeat (54) @(posedge CLK);
    #1;
    check("active_before_reset", {DE, pix_x, pix_y}, {1'b1, 10'd3, 10'd0});
    @(negedge CLK) nRESET = 1'b0;
    @(posedge CLK); #1;
    check("midline_reset_outputs",
          {Hsync, Vsync, DE, pix_x, pix_y, line_start, frame_start, busy, pix_ce},
          {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 4'b0000});
    @(negedge CLK) nRESET = 1'b1;
    tr = cyc;
    wait_fs(t2);
    check("restart_latency", t2 - tr, 2);

    repeat (6) @(posedge CLK);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    check("scoreboard_active", (sb_count > 100) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
